// File: rtl/uart_tx_arbiter_if.sv
// Channel push, arbitration control and UART-side signals of uart_tx_arbiter.
// Macro UART_TX_ARBITER_DROP_CNT_EN adds the per-channel drop_cnt bundle.
interface uart_tx_arbiter_if #(
    parameter int N_CH = 2
);
    localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [N_CH-1:0]   ch_valid;
    logic [8*N_CH-1:0] ch_bits;
    logic [N_CH-1:0]   ch_ready;
    logic [SEL_W-1:0]  owner_sel;
    logic              rr_mode;
    logic              tx_ready;
    logic [7:0]        tx_bits;
    logic              busy;
    logic [SEL_W-1:0]  grant;
    logic [N_CH-1:0]   fifo_empty;
`ifdef UART_TX_ARBITER_DROP_CNT_EN
    logic [8*N_CH-1:0] drop_cnt;

    modport master (
        output ch_valid, ch_bits, owner_sel, rr_mode, tx_ready,
        input  ch_ready, tx_bits, busy, grant, fifo_empty, drop_cnt
    );
    modport slave (
        input  ch_valid, ch_bits, owner_sel, rr_mode, tx_ready,
        output ch_ready, tx_bits, busy, grant, fifo_empty, drop_cnt
    );
`else
    modport master (
        output ch_valid, ch_bits, owner_sel, rr_mode, tx_ready,
        input  ch_ready, tx_bits, busy, grant, fifo_empty
    );
    modport slave (
        input  ch_valid, ch_bits, owner_sel, rr_mode, tx_ready,
        output ch_ready, tx_bits, busy, grant, fifo_empty
    );
`endif
endinterface

// File: rtl/uart_tx_arbiter.sv
// Per-channel byte FIFOs arbitrated (owner or round-robin) onto one UART byte.
// Macro UART_TX_ARBITER_DROP_CNT_EN adds saturating per-channel dropped-push counters.
module uart_tx_arbiter #(
    parameter int         N_CH      = 2,
    parameter int         DEPTH     = 4,
    parameter logic [7:0] IDLE_BYTE = 8'h00
) (
    input logic              clock,
    input logic              reset,
    uart_tx_arbiter_if.slave bus
);
    localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_SEND = 1'b1} state_t;

    logic [7:0]       mem_r    [N_CH][DEPTH];
    logic [PTR_W-1:0] wr_ptr_r [N_CH];
    logic [PTR_W-1:0] rd_ptr_r [N_CH];
    logic [CNT_W-1:0] cnt_r    [N_CH];
    logic [N_CH-1:0]  full_s;
    logic [N_CH-1:0]  empty_s;
    logic [N_CH-1:0]  push_s;
    logic [N_CH-1:0]  pop_s;

    state_t           state_r, state_nx_s;
    logic [7:0]       tx_bits_r, tx_bits_nx_s;
    logic [SEL_W-1:0] grant_r, grant_nx_s;
    logic [SEL_W-1:0] last_grant_r, last_grant_nx_s;
    logic             found_s;
    logic [SEL_W-1:0] sel_s;
    logic [7:0]       head_s;
    int               cand_s;

    // FIFO status flags and push qualification; pushes are ignored in reset
    always_comb begin
        full_s  = '0;
        empty_s = '0;
        push_s  = '0;
        for (int k = 0; k < N_CH; k++) begin
            full_s[k]  = (cnt_r[k] == CNT_W'(DEPTH));
            empty_s[k] = (cnt_r[k] == CNT_W'(0));
            push_s[k]  = bus.ch_valid[k] & ~full_s[k] & ~reset;
        end
    end

    // FIFO storage, written without reset since occupancy gates every read
    always_ff @(posedge clock) begin
        for (int k = 0; k < N_CH; k++) begin
            if (push_s[k]) begin
                mem_r[k][wr_ptr_r[k]] <= bus.ch_bits[8*k +: 8];
            end
        end
    end

    // FIFO pointers and occupancy; push and pop in one cycle leave occupancy unchanged
    always_ff @(posedge clock) begin
        for (int k = 0; k < N_CH; k++) begin
            if (reset) begin
                wr_ptr_r[k] <= '0;
                rd_ptr_r[k] <= '0;
                cnt_r[k]    <= '0;
            end else begin
                if (push_s[k]) wr_ptr_r[k] <= wr_ptr_r[k] + PTR_W'(1);
                if (pop_s[k])  rd_ptr_r[k] <= rd_ptr_r[k] + PTR_W'(1);
                case ({push_s[k], pop_s[k]})
                    2'b10:   cnt_r[k] <= cnt_r[k] + CNT_W'(1);
                    2'b01:   cnt_r[k] <= cnt_r[k] - CNT_W'(1);
                    default: cnt_r[k] <= cnt_r[k];
                endcase
            end
        end
    end

    // Eligible channel selection from pre-edge occupancy, so a byte pushed this cycle waits
    always_comb begin
        found_s = 1'b0;
        sel_s   = '0;
        head_s  = IDLE_BYTE;
        cand_s  = 0;
        if (bus.rr_mode) begin
            for (int i = 1; i <= N_CH; i++) begin
                cand_s = (int'(last_grant_r) + i) % N_CH;
                for (int k = 0; k < N_CH; k++) begin
                    if (!found_s && cand_s == k && !empty_s[k]) begin
                        found_s = 1'b1;
                        sel_s   = SEL_W'(k);
                        head_s  = mem_r[k][rd_ptr_r[k]];
                    end
                end
            end
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                if (int'(bus.owner_sel) == k && !empty_s[k]) begin
                    found_s = 1'b1;
                    sel_s   = SEL_W'(k);
                    head_s  = mem_r[k][rd_ptr_r[k]];
                end
            end
        end
    end

    // Next state: every tx_ready cycle either pops the selected head or falls back to idle
    always_comb begin
        state_nx_s      = state_r;
        tx_bits_nx_s    = tx_bits_r;
        grant_nx_s      = grant_r;
        last_grant_nx_s = last_grant_r;
        pop_s           = '0;
        case (state_r)
            ST_IDLE, ST_SEND: begin
                if (bus.tx_ready) begin
                    if (found_s) begin
                        state_nx_s      = ST_SEND;
                        tx_bits_nx_s    = head_s;
                        grant_nx_s      = sel_s;
                        last_grant_nx_s = sel_s;
                        for (int k = 0; k < N_CH; k++) begin
                            pop_s[k] = (sel_s == SEL_W'(k));
                        end
                    end else begin
                        state_nx_s   = ST_IDLE;
                        tx_bits_nx_s = IDLE_BYTE;
                    end
                end else begin
                    state_nx_s = state_r;
                end
            end
            default: begin
                state_nx_s   = ST_IDLE;
                tx_bits_nx_s = IDLE_BYTE;
            end
        endcase
    end

    // State and registered UART-side outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            tx_bits_r    <= IDLE_BYTE;
            grant_r      <= '0;
            last_grant_r <= SEL_W'(N_CH - 1);
        end else begin
            state_r      <= state_nx_s;
            tx_bits_r    <= tx_bits_nx_s;
            grant_r      <= grant_nx_s;
            last_grant_r <= last_grant_nx_s;
        end
    end

    assign bus.tx_bits    = tx_bits_r;
    assign bus.busy       = (state_r == ST_SEND);
    assign bus.grant      = grant_r;
    assign bus.ch_ready   = ~full_s;
    assign bus.fifo_empty = empty_s;

`ifdef UART_TX_ARBITER_DROP_CNT_EN
    logic [7:0] drop_cnt_r [N_CH];

    // Saturating count of pushes rejected because the channel FIFO was full
    always_ff @(posedge clock) begin
        for (int k = 0; k < N_CH; k++) begin
            if (reset) begin
                drop_cnt_r[k] <= 8'h00;
            end else if (bus.ch_valid[k] && full_s[k] && drop_cnt_r[k] != 8'hFF) begin
                drop_cnt_r[k] <= drop_cnt_r[k] + 8'h01;
            end else begin
                drop_cnt_r[k] <= drop_cnt_r[k];
            end
        end
    end

    always_comb begin
        bus.drop_cnt = '0;
        for (int k = 0; k < N_CH; k++) begin
            bus.drop_cnt[8*k +: 8] = drop_cnt_r[k];
        end
    end
`endif
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: queue-based reference model compared every
// cycle, plus hand-computed expectations for the key scenarios.
module tb_uart_tx_arbiter;
    localparam int         N     = 2;
    localparam int         DEPTH = 4;
    localparam logic [7:0] IDLE  = 8'h00;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    uart_tx_arbiter_if #(.N_CH(N)) bus ();

    uart_tx_arbiter #(.N_CH(N), .DEPTH(DEPTH), .IDLE_BYTE(IDLE)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0] mq [N][$];
    logic [7:0] m_tx    = IDLE;
    logic       m_busy  = 1'b0;
    int         m_grant = 0;
    int         m_last  = N - 1;
    int         m_drop [N];
    bit         m_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: pick from queue sizes seen before the edge, then apply pushes.
    task automatic model_step();
        bit full [N];
        int pick;
        int c;
        if (reset) begin
            for (int k = 0; k < N; k++) begin
                mq[k].delete();
                m_drop[k] = 0;
            end
            m_tx = IDLE; m_busy = 1'b0; m_grant = 0; m_last = N - 1;
        end else begin
            for (int k = 0; k < N; k++) full[k] = (mq[k].size() >= DEPTH);
            pick = -1;
            if (bus.tx_ready) begin
                if (bus.rr_mode) begin
                    for (int i = 1; i <= N; i++) begin
                        c = (m_last + i) % N;
                        if (pick < 0 && mq[c].size() > 0) pick = c;
                    end
                end else if (int'(bus.owner_sel) < N && mq[int'(bus.owner_sel)].size() > 0) begin
                    pick = int'(bus.owner_sel);
                end
                if (pick >= 0) begin
                    m_tx = mq[pick].pop_front();
                    m_busy = 1'b1; m_grant = pick; m_last = pick;
                end else begin
                    m_tx = IDLE; m_busy = 1'b0;
                end
            end
            for (int k = 0; k < N; k++) begin
                if (bus.ch_valid[k]) begin
                    if (!full[k]) mq[k].push_back(bus.ch_bits[8*k +: 8]);
                    else if (m_drop[k] < 255) m_drop[k]++;
                end
            end
        end
        m_valid = 1'b1;
    endtask

    always @(negedge clock) begin
        if (m_valid) begin
            check("m_tx_bits", 32'(bus.tx_bits), 32'(m_tx));
            check("m_busy", 32'(bus.busy), 32'(m_busy));
            if (m_busy) check("m_grant", 32'(bus.grant), 32'(m_grant));
            for (int k = 0; k < N; k++) begin
                check("m_ch_ready", 32'(bus.ch_ready[k]), 32'(mq[k].size() < DEPTH));
                check("m_fifo_empty", 32'(bus.fifo_empty[k]), 32'(mq[k].size() == 0));
`ifdef UART_TX_ARBITER_DROP_CNT_EN
                check("m_drop_cnt", 32'(bus.drop_cnt[8*k +: 8]), 32'(m_drop[k]));
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        model_step();
        @(negedge clock);
    endtask

    task automatic push(input int ch, input logic [7:0] b);
        bus.ch_valid = '0;
        bus.ch_valid[ch] = 1'b1;
        bus.ch_bits[8*ch +: 8] = b;
        tick();
        bus.ch_valid = '0;
    endtask

    task automatic pulse();
        bus.tx_ready = 1'b1;
        tick();
        bus.tx_ready = 1'b0;
        tick();
    endtask

    logic [7:0] exp_b;

    initial begin
        bus.ch_valid = '0; bus.ch_bits = '0; bus.owner_sel = '0;
        bus.rr_mode = 1'b0; bus.tx_ready = 1'b0;
        reset = 1'b1;
        tick();
        bus.ch_valid = 2'b11; bus.ch_bits = 16'h5A5A; bus.tx_ready = 1'b1;
        tick();
        bus.ch_valid = '0; bus.tx_ready = 1'b0;
        check("rst_tx_bits", 32'(bus.tx_bits), 32'h00);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_grant", 32'(bus.grant), 32'h0);
        check("rst_fifo_empty", 32'(bus.fifo_empty), 32'h3);
        check("rst_ch_ready", 32'(bus.ch_ready), 32'h3);
        reset = 1'b0;
        tick();

        // owner mode on channel 1
        bus.owner_sel = 1'b1;
        push(1, 8'h21);
        push(1, 8'h22);
        pulse();
        check("own_b0", 32'(bus.tx_bits), 32'h21);
        check("own_busy0", 32'(bus.busy), 32'h1);
        check("own_grant0", 32'(bus.grant), 32'h1);
        pulse();
        check("own_b1", 32'(bus.tx_bits), 32'h22);
        pulse();
        check("own_b2", 32'(bus.tx_bits), 32'h00);
        check("own_busy2", 32'(bus.busy), 32'h0);

        // round-robin
        bus.rr_mode = 1'b1;
        bus.ch_valid = 2'b11; bus.ch_bits = 16'h1101;
        tick();
        push(0, 8'h02);
        pulse(); check("rr_0", 32'(bus.tx_bits), 32'h01);
        pulse(); check("rr_1", 32'(bus.tx_bits), 32'h11);
        pulse(); check("rr_2", 32'(bus.tx_bits), 32'h02);
        pulse(); check("rr_3", 32'(bus.tx_bits), 32'h00);

        // overflow on channel 0, then drain with tx_ready held high
        bus.rr_mode = 1'b0; bus.owner_sel = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.ch_valid[0] = 1'b1;
            bus.ch_bits[7:0] = 8'hAA + 8'(i);
            tick();
            if (i == 3) check("full_ready", 32'(bus.ch_ready[0]), 32'h0);
        end
        bus.ch_valid = '0;
`ifdef UART_TX_ARBITER_DROP_CNT_EN
        check("drop_cnt0", 32'(bus.drop_cnt[7:0]), 32'h1);
`endif
        bus.tx_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            exp_b = (i < 4) ? (8'hAA + 8'(i)) : 8'h00;
            check("drain", 32'(bus.tx_bits), 32'(exp_b));
        end
        bus.tx_ready = 1'b0;
        tick();

        // ineligible owner, then switch
        push(1, 8'h33);
        pulse(); check("sw_idle", 32'(bus.tx_bits), 32'h00);
        bus.owner_sel = 1'b1;
        pulse(); check("sw_33", 32'(bus.tx_bits), 32'h33);
        bus.owner_sel = 1'b0;

        // push concurrent with tx_ready is not yet eligible
        bus.ch_valid[0] = 1'b1; bus.ch_bits[7:0] = 8'h44; bus.tx_ready = 1'b1;
        tick();
        bus.ch_valid = '0; bus.tx_ready = 1'b0;
        check("lat_idle", 32'(bus.tx_bits), 32'h00);
        tick();
        pulse(); check("lat_44", 32'(bus.tx_bits), 32'h44);

        // simultaneous push and pop keeps occupancy
        push(0, 8'h70);
        bus.ch_valid[0] = 1'b1; bus.ch_bits[7:0] = 8'h71; bus.tx_ready = 1'b1;
        tick();
        bus.ch_valid = '0; bus.tx_ready = 1'b0;
        check("pp_70", 32'(bus.tx_bits), 32'h70);
        check("pp_nonempty", 32'(bus.fifo_empty[0]), 32'h0);
        pulse(); check("pp_71", 32'(bus.tx_bits), 32'h71);

        // reset while sending with bytes queued
        for (int i = 0; i < 4; i++) push(0, 8'h61 + 8'(i));
        pulse();
        check("mid_busy", 32'(bus.busy), 32'h1);
        check("mid_61", 32'(bus.tx_bits), 32'h61);
        reset = 1'b1;
        tick();
        check("rs_tx", 32'(bus.tx_bits), 32'h00);
        check("rs_empty", 32'(bus.fifo_empty), 32'h3);
        check("rs_busy", 32'(bus.busy), 32'h0);
        reset = 1'b0;
        pulse(); check("rs_after", 32'(bus.tx_bits), 32'h00);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter N_CH, default 2: number of byte-source channels (e.g. manual, script); range 2..8.
REQ-002 Parameter DEPTH, default 4: per-channel FIFO depth in bytes; power of two, range 2..16.
REQ-003 Parameter IDLE_BYTE, default 8'h00: byte presented to UART when nothing is granted.
REQ-004 clock  in  1  UART 16x baud clock; the block's only clock.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 ch_valid  in  N_CH  per-channel push strobe; one byte per asserted cycle.
REQ-007 ch_bits  in  8*N_CH  per-channel push byte; channel k occupies bits [8k+7:8k].
REQ-008 ch_ready  out  N_CH  channel k FIFO not full.
REQ-009 owner_sel  in  clog2(N_CH)  owning channel in owner mode.
REQ-010 rr_mode  in  1  0 = owner mode, 1 = round-robin over all channels.
REQ-011 tx_ready  in  1  UART io_dataIn_ready; one-cycle pulse when the presented byte has been sent.
REQ-012 tx_bits  out  8  byte to UART io_dataIn_bits.
REQ-013 busy  out  1  high in SEND state.
REQ-014 grant  out  clog2(N_CH)  channel whose byte is on tx_bits; valid only when busy=1.
REQ-015 fifo_empty  out  N_CH  channel k FIFO empty.

Function
REQ-016 Each channel SHALL have an independent DEPTH-entry FIFO; push occurs when ch_valid[k]=1 and ch_ready[k]=1.
REQ-017 A push while full SHALL be dropped, leave FIFO contents unchanged, and not stall other channels.
REQ-018 Simultaneous push and pop on one channel SHALL both take effect; occupancy unchanged.
REQ-019 A byte pushed in cycle t SHALL be eligible for pop no earlier than cycle t+1.
REQ-020 FSM states: IDLE (tx_bits=IDLE_BYTE, busy=0) and SEND (tx_bits=granted byte, busy=1).
REQ-021 tx_bits SHALL change only on the clock edge ending a cycle with tx_ready=1; between pulses it is held stable.
REQ-022 On a tx_ready pulse, in either state: if an eligible channel is non-empty, pop its head into tx_bits, set grant, enter/stay SEND; otherwise load IDLE_BYTE and enter/stay IDLE.
REQ-023 Owner mode eligibility: only channel owner_sel; owner_sel >= N_CH SHALL make no channel eligible.
REQ-024 Round-robin eligibility: first non-empty channel searching upward from last_grant+1, wrapping at N_CH; last_grant resets to N_CH-1 so channel 0 wins first.
REQ-025 Changes to owner_sel or rr_mode SHALL take effect only at the next tx_ready pulse; the in-flight byte is never altered.
REQ-026 tx_ready pulses lasting more than one cycle SHALL cause one pop per high cycle, with no edge detection.
REQ-027 Latency: a byte pushed into an empty, eligible FIFO appears on tx_bits at the edge ending the first tx_ready pulse that is at least one cycle after the push.

Reset
REQ-028 While reset=1: all FIFOs empty, state IDLE, tx_bits=IDLE_BYTE, busy=0, grant=0, last_grant=N_CH-1, ch_ready=all 1, fifo_empty=all 1.
REQ-029 Reset mid-SEND SHALL discard the in-flight byte and all queued bytes; pushes and tx_ready are ignored during reset.

Configuration
REQ-030 Macro UART_TX_ARBITER_DROP_CNT_EN defined: output drop_cnt (8*N_CH) is present, one 8-bit saturating counter per channel, incremented per dropped push, saturating at 8'hFF and cleared by reset.
REQ-031 Macro UART_TX_ARBITER_DROP_CNT_EN undefined: no drop_cnt port and no counter logic; all other behaviour is identical.

Verification
REQ-032 Owner mode, owner_sel=1, push 8'h21, 8'h22 on ch1, pulse tx_ready 3 times -> tx_bits 8'h21, 8'h22, then IDLE_BYTE; busy falls after the third pulse.
REQ-033 Round-robin, ch0 holds {8'h01, 8'h02}, ch1 holds {8'h11}, pulse tx_ready 4 times -> tx_bits sequence 01, 11, 02, 00.
REQ-034 DEPTH=4, push 5 bytes on ch0 with no tx_ready -> ch_ready[0]=0 after the 4th push, 5th byte lost; with the macro defined, drop_cnt[7:0]=1.
REQ-035 Owner mode, owner_sel=0, ch0 empty, ch1 holds 8'h33, tx_ready pulse -> tx_bits stays IDLE_BYTE; switch owner_sel=1 and pulse again -> tx_bits=8'h33.
REQ-036 Assert reset while busy=1 with 3 bytes queued -> next cycle tx_bits=IDLE_BYTE, fifo_empty all 1; following tx_ready pulse yields IDLE_BYTE.
